// File: rtl/bit_counter.sv
// bit_counter -- registered population count of an input word with status flags
// Rev 1.0
`default_nettype none

module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inbyte,
  output logic [CNT_W-1:0] numones,
  output logic             out_valid,
  output logic             all_zero,
  output logic             all_ones,
  output logic             parity
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] vec);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + CNT_W'(vec[i]);
    end
    return acc;
  endfunction

  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = popcount(inbyte);
  end

  // Flags come from the same next-count value, so they always agree with numones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      numones   <= '0;
      out_valid <= 1'b0;
      all_zero  <= 1'b1;
      all_ones  <= 1'b0;
      parity    <= 1'b0;
    end else begin
      numones   <= count_next;
      out_valid <= 1'b1;
      all_zero  <= (count_next == '0);
      all_ones  <= (count_next == FULL_COUNT);
      parity    <= count_next[0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_counter.sv
// tb_bit_counter -- scoreboard bench for bit_counter
// Rev 1.0
`default_nettype none

module tb_bit_counter;

  logic       clk;
  logic       rst;
  logic [7:0] inbyte;
  logic [3:0] numones;
  logic       out_valid;
  logic       all_zero;
  logic       all_ones;
  logic       parity;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  bit_counter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .inbyte   (inbyte),
    .numones  (numones),
    .out_valid(out_valid),
    .all_zero (all_zero),
    .all_ones (all_ones),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {count, valid, zero, ones, parity}
  function automatic logic [7:0] expect_word(input logic [3:0] c);
    return {c, 1'b1, (c == 4'd0), (c == 4'd8), c[0]};
  endfunction

  function automatic logic [7:0] actual_word();
    return {numones, out_valid, all_zero, all_ones, parity};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d v=%b z=%b o=%b p=%b, want cnt=%0d v=%b z=%b o=%b p=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic [3:0] c);
    @(negedge clk);
    inbyte = v;
    @(posedge clk);
    exp_q.push_back(expect_word(c));
  endtask

  // Monitor: outputs registered at the previous rising edge are checked here.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("stream", actual_word(), exp_q.pop_front());
    end
  end

  localparam logic [7:0] RESET_WORD = 8'b0000_0_1_0_0;

  logic [7:0] sweep_v [9] = '{8'h00, 8'h01, 8'h03, 8'h83, 8'hC3, 8'hC7, 8'hE7, 8'hEF, 8'hFF};
  logic [3:0] sweep_c [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  initial begin
    logic [7:0] r;
    rst    = 1'b1;
    inbyte = 8'hFF;
    #1;
    check("reset_async", actual_word(), RESET_WORD);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", actual_word(), RESET_WORD);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) send(sweep_v[i], sweep_c[i]);
    for (int i = 0; i < 8; i++) begin
      r = 8'h01 << i;
      send(r, 4'd1);
    end
    send(8'hAA, 4'd4);
    send(8'h55, 4'd4);
    send(8'h55, 4'd4);
    @(negedge clk);

    // Short reset pulse between edges, with 0F waiting on the input
    inbyte = 8'h0F;
    #2;
    rst = 1'b1;
    #1;
    check("midstream_reset", actual_word(), RESET_WORD);
    #1;
    rst = 1'b0;
    #1;
    check("midstream_hold", actual_word(), RESET_WORD);
    @(posedge clk);
    exp_q.push_back(expect_word(4'd4));

    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom_range(0, 255));
      send(r, 4'($countones(r)));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
